mem_arbiter: RTL and testbench

Parametrised byte-serial memory controller sitting between the CPU's requesters (instruction fetcher, load/store buffer, future units) and the single 8-bit RAM/IO bus. It accepts byte/half/word read and write requests on NCH independent channels, arbitrates them round-robin, and serialises each access onto the bus. It adds flush-abort of selected channels and optional IO back-pressure.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_if.sv | 34 +++
 rtl/mem_arb_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter: size codes,
// controller states, IO address window and the size-to-byte-count mapping.
package mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] IO_WINDOW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } arb_state_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request/response channels plus the 8-bit RAM/IO bus of mem_arbiter.
// slave = the arbiter, master = requesters and the RAM/IO side.
interface mem_arb_if #(parameter int NCH = 2);

    logic                 rdy_in;
    logic [7:0]           mem_din;
    logic [7:0]           mem_dout;
    logic [31:0]          mem_a;
    logic                 mem_wr;
    logic                 io_buffer_full;
    logic                 flush_in;
    logic [NCH-1:0]       req_valid;
    logic [NCH-1:0]       req_ready;
    logic [NCH-1:0]       req_we;
    logic [2*NCH-1:0]     req_size;
    logic [32*NCH-1:0]    req_addr;
    logic [32*NCH-1:0]    req_wdata;
    logic [NCH-1:0]       resp_valid;
    logic [31:0]          resp_data;
    logic                 busy;

    modport slave (
        input  rdy_in, mem_din, io_buffer_full, flush_in,
               req_valid, req_we, req_size, req_addr, req_wdata,
        output mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data, busy
    );

    modport master (
        output rdy_in, mem_din, io_buffer_full, flush_in,
               req_valid, req_we, req_size, req_addr, req_wdata,
        input  mem_dout, mem_a, mem_wr, req_ready, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter: grants the first requesting channel at or after ptr,
// wrapping modulo NCH. Purely combinational.
module mem_arb_rr #(
    parameter int NCH = 2,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [PW-1:0]  grant_idx,
    output logic           grant_any
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] idx_s;
    logic          hit_s;

    // scan channels starting from the pointer; first hit wins
    always_comb begin
        grant     = {NCH{1'b0}};
        grant_idx = {PW{1'b0}};
        grant_any = 1'b0;
        sum_s     = {(PW+1){1'b0}};
        idx_s     = {PW{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            sum_s        = {1'b0, ptr} + (PW+1)'(i);
            idx_s        = (sum_s >= (PW+1)'(NCH)) ? PW'(sum_s - (PW+1)'(NCH)) : PW'(sum_s);
            hit_s        = ~grant_any & req[idx_s];
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx    = hit_s ? idx_s : grant_idx;
            grant_any    = grant_any | hit_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller: round-robin over NCH request channels,
// one bus byte per active cycle, flush abort of masked reads.
// Optional IO write back-pressure under `define MEM_ARB_IO_THROTTLE_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int             NCH        = 2,
    parameter logic [NCH-1:0] FLUSH_MASK = NCH'(1'b1)
) (
    input logic       clk_in,
    input logic       rst_in,
    mem_arb_if.slave  bus
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    arb_state_e     state_r, state_s;
    logic [PW-1:0]  owner_r, rr_ptr_r, grant_idx_s;
    logic [NCH-1:0] grant_s, req_mask_s, resp_valid_s;
    logic           grant_any_s, we_r, cap_r, busy_r;
    logic [2:0]     nbytes_r;
    logic [1:0]     k_r, cap_k_r;
    logic [31:0]    addr_r, wdata_r, data_r, merged_s, byte_addr_s;
    logic [31:0]    sel_addr_s, sel_wdata_s;
    logic [1:0]     sel_size_s;
    logic           sel_we_s;
    logic [7:0]     wbyte_s;
    logic           throttle_s, active_s, issue_s, last_s, abort_s, accept_s, done_ok_s;

    assign req_mask_s = bus.req_valid & ~(bus.flush_in ? FLUSH_MASK : {NCH{1'b0}});

    mem_arb_rr #(.NCH(NCH), .PW(PW)) u_rr (
        .req       (req_mask_s),
        .ptr       (rr_ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

    assign byte_addr_s = addr_r + {30'h0, k_r};

    // IO back-pressure: stall an IO-window write byte while the UART is full
    always_comb begin
        throttle_s = 1'b0;
`ifdef MEM_ARB_IO_THROTTLE_EN
        throttle_s = (state_r == ST_XFER) && we_r && (byte_addr_s[17:16] == IO_WINDOW)
                     && bus.io_buffer_full;
`else
        throttle_s = bus.io_buffer_full & 1'b0;
`endif
    end

    assign active_s  = bus.rdy_in & ~throttle_s;
    assign issue_s   = (state_r == ST_XFER) & active_s;
    assign last_s    = ({1'b0, k_r} == (nbytes_r - 3'd1));
    assign abort_s   = (state_r != ST_IDLE) & ~we_r & FLUSH_MASK[owner_r] & bus.flush_in & bus.rdy_in;
    assign accept_s  = (state_r == ST_IDLE) & bus.rdy_in & ~rst_in & grant_any_s;
    assign done_ok_s = (state_r == ST_DONE) & bus.rdy_in & ~abort_s;

    // pick the granted channel's request fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_size_s  = 2'b00;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        for (int i = 0; i < NCH; i++) begin
            sel_we_s    = (grant_idx_s == PW'(i)) ? bus.req_we[i]            : sel_we_s;
            sel_size_s  = (grant_idx_s == PW'(i)) ? bus.req_size[2*i +: 2]   : sel_size_s;
            sel_addr_s  = (grant_idx_s == PW'(i)) ? bus.req_addr[32*i +: 32] : sel_addr_s;
            sel_wdata_s = (grant_idx_s == PW'(i)) ? bus.req_wdata[32*i +: 32] : sel_wdata_s;
        end
    end

    // write byte k of the latched data
    always_comb begin
        wbyte_s = 8'h00;
        case (k_r)
            2'd0:    wbyte_s = wdata_r[7:0];
            2'd1:    wbyte_s = wdata_r[15:8];
            2'd2:    wbyte_s = wdata_r[23:16];
            default: wbyte_s = wdata_r[31:24];
        endcase
    end

    // fold the byte returning this cycle into the assembled read data
    always_comb begin
        merged_s = data_r;
        if (cap_r) begin
            case (cap_k_r)
                2'd0:    merged_s[7:0]   = bus.mem_din;
                2'd1:    merged_s[15:8]  = bus.mem_din;
                2'd2:    merged_s[23:16] = bus.mem_din;
                default: merged_s[31:24] = bus.mem_din;
            endcase
        end else begin
            merged_s = data_r;
        end
    end

    // completion pulse to the owning channel
    always_comb begin
        resp_valid_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            resp_valid_s[i] = done_ok_s & (owner_r == PW'(i));
        end
    end

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_XFER;
                else          state_s = ST_IDLE;
            end
            ST_XFER: begin
                if (abort_s)               state_s = ST_IDLE;
                else if (issue_s && last_s) state_s = ST_DONE;
                else                        state_s = ST_XFER;
            end
            ST_DONE: begin
                if (bus.rdy_in) state_s = ST_IDLE;
                else            state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r  <= ST_IDLE;
            owner_r  <= {PW{1'b0}};
            rr_ptr_r <= {PW{1'b0}};
            we_r     <= 1'b0;
            nbytes_r <= 3'd0;
            k_r      <= 2'd0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            data_r   <= 32'h0;
            cap_r    <= 1'b0;
            cap_k_r  <= 2'd0;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            // a capture still completes in a frozen cycle; nothing new is issued
            cap_r   <= issue_s & ~we_r & ~abort_s;
            data_r  <= merged_s;
            if (issue_s) cap_k_r <= k_r;
            if (accept_s) begin
                owner_r  <= grant_idx_s;
                rr_ptr_r <= (grant_idx_s == PW'(NCH-1)) ? {PW{1'b0}} : grant_idx_s + PW'(1);
                we_r     <= sel_we_s;
                nbytes_r <= byte_count(sel_size_s);
                addr_r   <= sel_addr_s;
                wdata_r  <= sel_wdata_s;
                k_r      <= 2'd0;
                data_r   <= 32'h0;
            end else if (issue_s && !abort_s) begin
                k_r <= k_r + 2'd1;
            end
        end
    end

    assign bus.mem_a      = byte_addr_s;
    assign bus.mem_dout   = wbyte_s;
    assign bus.mem_wr     = issue_s & we_r;
    assign bus.req_ready  = accept_s ? grant_s : {NCH{1'b0}};
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_data  = (done_ok_s & ~we_r) ? merged_s : 32'h0;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;

    logic clk_in = 1'b0;
    logic rst_in;
    int   tests = 0;
    int   fails = 0;
    logic [1:0] c_exp [4];

    mem_arb_if #(.NCH(2)) bus ();

    mem_arbiter #(.NCH(2), .FLUSH_MASK(2'b01)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h200: return 8'hAA;
            32'h201: return 8'hBB;
            32'h202: return 8'hCC;
            32'h203: return 8'hDD;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM read port: data for the address of cycle t appears in cycle t+1
    always @(posedge clk_in) bus.mem_din <= rom(bus.mem_a);

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic we, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we[ch]            = we;
        bus.req_size[2*ch +: 2]   = size;
        bus.req_addr[32*ch +: 32] = addr;
        bus.req_wdata[32*ch +: 32] = wdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        c_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
        rst_in             = 1'b1;
        bus.rdy_in         = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.flush_in       = 1'b0;
        bus.req_valid      = 2'b11;
        bus.req_we         = 2'b00;
        bus.req_size       = 4'h0;
        bus.req_addr       = 64'h0;
        bus.req_wdata      = 64'h0;

        // reset state
        #2;
        chk("rst_mem_a", bus.mem_a, 32'h0);
        chk("rst_mem_dout", {24'h0, bus.mem_dout}, 32'h0);
        chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("rst_req_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("rst_resp_valid", {30'h0, bus.resp_valid}, 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        @(negedge clk_in);
        rst_in        = 1'b0;
        bus.req_valid = 2'b00;

        // channel 1 word read at 0x100
        tick();
        set_req(1, 1'b0, 2'b10, 32'h100, 32'h0);
        bus.req_valid = 2'b10;
        #2 chk("a_ready", {30'h0, bus.req_ready}, 32'h2);
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("a_addr", bus.mem_a, 32'h100 + i);
            chk("a_wr", {31'h0, bus.mem_wr}, 32'h0);
            chk("a_no_resp", {30'h0, bus.resp_valid}, 32'h0);
            tick();
        end
        #2;
        chk("a_resp_valid", {30'h0, bus.resp_valid}, 32'h2);
        chk("a_resp_data", bus.resp_data, 32'h44332211);
        chk("a_busy", {31'h0, bus.busy}, 32'h1);
        tick();
        #2;
        chk("a_idle_busy", {31'h0, bus.busy}, 32'h0);
        chk("a_resp_clr", {30'h0, bus.resp_valid}, 32'h0);

        // channel 0 half write 0xBEEF at 0x20
        tick();
        set_req(0, 1'b1, 2'b01, 32'h20, 32'h0000BEEF);
        bus.req_valid = 2'b01;
        #2 chk("b_ready", {30'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("b_wr0", {31'h0, bus.mem_wr}, 32'h1);
        chk("b_addr0", bus.mem_a, 32'h20);
        chk("b_dout0", {24'h0, bus.mem_dout}, 32'hEF);
        tick();
        #2;
        chk("b_wr1", {31'h0, bus.mem_wr}, 32'h1);
        chk("b_addr1", bus.mem_a, 32'h21);
        chk("b_dout1", {24'h0, bus.mem_dout}, 32'hBE);
        tick();
        #2;
        chk("b_resp_valid", {30'h0, bus.resp_valid}, 32'h1);
        chk("b_resp_data", bus.resp_data, 32'h0);
        chk("b_wr_done", {31'h0, bus.mem_wr}, 32'h0);

        // both channels request continuously: grants alternate
        tick();
        set_req(0, 1'b0, 2'b00, 32'h100, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h101, 32'h0);
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            int w;
            w = 0;
            #2;
            while (bus.req_ready == 2'b00 && w < 8) begin
                tick();
                #2;
                w++;
            end
            chk("c_grant", {30'h0, bus.req_ready}, {30'h0, c_exp[g]});
            tick();
        end
        bus.req_valid = 2'b00;
        tick();
        #2;
        chk("c_last_resp", {30'h0, bus.resp_valid}, 32'h1);
        chk("c_byte_data", bus.resp_data, 32'h11);

        // channel 0 word read aborted by flush at A+2
        tick();
        set_req(0, 1'b0, 2'b10, 32'h100, 32'h0);
        bus.req_valid = 2'b01;
        #2 chk("d_ready", {30'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #2 chk("d_busy", {31'h0, bus.busy}, 32'h1);
        tick();
        bus.flush_in = 1'b1;
        #2;
        chk("d_flush_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("d_flush_resp", {30'h0, bus.resp_valid}, 32'h0);
        tick();
        bus.flush_in = 1'b0;
        #2;
        chk("d_busy_low", {31'h0, bus.busy}, 32'h0);
        chk("d_no_resp", {30'h0, bus.resp_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2 chk("d_no_resp_late", {30'h0, bus.resp_valid}, 32'h0);
        end

        // channel 1 byte write under flush still completes
        tick();
        set_req(1, 1'b1, 2'b00, 32'h40, 32'h0000005A);
        bus.req_valid = 2'b10;
        bus.flush_in  = 1'b1;
        #2 chk("d2_ready", {30'h0, bus.req_ready}, 32'h2);
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("d2_wr", {31'h0, bus.mem_wr}, 32'h1);
        chk("d2_dout", {24'h0, bus.mem_dout}, 32'h5A);
        chk("d2_addr", bus.mem_a, 32'h40);
        tick();
        #2;
        chk("d2_resp", {30'h0, bus.resp_valid}, 32'h2);
        chk("d2_resp_data", bus.resp_data, 32'h0);

        // masked channel not granted while flush is high
        tick();
        set_req(0, 1'b0, 2'b00, 32'h100, 32'h0);
        bus.req_valid = 2'b01;
        #2 chk("d3_flush_mask", {30'h0, bus.req_ready}, 32'h0);
        bus.flush_in = 1'b0;
        #1 chk("d3_flush_release", {30'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        #2;
        chk("d3_resp", {30'h0, bus.resp_valid}, 32'h1);
        chk("d3_data", bus.resp_data, 32'h11);

        // rdy_in low for 3 cycles during a word read
        tick();
        set_req(1, 1'b0, 2'b10, 32'h200, 32'h0);
        bus.req_valid = 2'b10;
        #2 chk("e_ready", {30'h0, bus.req_ready}, 32'h2);
        tick();
        bus.req_valid = 2'b00;
        #2 chk("e_addr0", bus.mem_a, 32'h200);
        tick();
        #2 chk("e_addr1", bus.mem_a, 32'h201);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.rdy_in = 1'b0;
            #2;
            chk("e_frozen_wr", {31'h0, bus.mem_wr}, 32'h0);
            chk("e_frozen_addr", bus.mem_a, 32'h202);
            chk("e_frozen_resp", {30'h0, bus.resp_valid}, 32'h0);
        end
        tick();
        bus.rdy_in = 1'b1;
        #2 chk("e_reissue", bus.mem_a, 32'h202);
        tick();
        #2;
        chk("e_addr3", bus.mem_a, 32'h203);
        chk("e_early_resp", {30'h0, bus.resp_valid}, 32'h0);
        tick();
        #2;
        chk("e_resp", {30'h0, bus.resp_valid}, 32'h2);
        chk("e_data", bus.resp_data, 32'hDDCCBBAA);

        // IO-window byte write with io_buffer_full high
        tick();
        set_req(0, 1'b1, 2'b00, 32'h30000, 32'h00000077);
        bus.req_valid      = 2'b01;
        bus.io_buffer_full = 1'b1;
        #2 chk("f_ready", {30'h0, bus.req_ready}, 32'h1);
`ifdef MEM_ARB_IO_THROTTLE_EN
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #2 chk("f_held", {31'h0, bus.mem_wr}, 32'h0);
            tick();
        end
        bus.io_buffer_full = 1'b0;
        #2;
        chk("f_wr", {31'h0, bus.mem_wr}, 32'h1);
        chk("f_dout", {24'h0, bus.mem_dout}, 32'h77);
        chk("f_addr", bus.mem_a, 32'h30000);
        tick();
        #2 chk("f_resp", {30'h0, bus.resp_valid}, 32'h1);
`else
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("f_wr", {31'h0, bus.mem_wr}, 32'h1);
        chk("f_dout", {24'h0, bus.mem_dout}, 32'h77);
        chk("f_addr", bus.mem_a, 32'h30000);
        tick();
        #2 chk("f_resp", {30'h0, bus.resp_valid}, 32'h1);
        bus.io_buffer_full = 1'b0;
`endif

        // asynchronous reset in the middle of a word write
        tick();
        set_req(0, 1'b1, 2'b10, 32'h80, 32'h12345678);
        bus.req_valid      = 2'b01;
        bus.io_buffer_full = 1'b0;
        #2 chk("g_ready", {30'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        #2;
        chk("g_wr", {31'h0, bus.mem_wr}, 32'h1);
        chk("g_dout0", {24'h0, bus.mem_dout}, 32'h78);
        tick();
        #2 chk("g_dout1", {24'h0, bus.mem_dout}, 32'h56);
        #1;
        rst_in        = 1'b1;
        bus.req_valid = 2'b11;
        set_req(1, 1'b0, 2'b00, 32'h100, 32'h0);
        set_req(0, 1'b0, 2'b00, 32'h100, 32'h0);
        #1;
        chk("g_rst_mem_a", bus.mem_a, 32'h0);
        chk("g_rst_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("g_rst_dout", {24'h0, bus.mem_dout}, 32'h0);
        chk("g_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("g_rst_ready", {30'h0, bus.req_ready}, 32'h0);
        chk("g_rst_resp", {30'h0, bus.resp_valid}, 32'h0);
        chk("g_rst_data", bus.resp_data, 32'h0);
        tick();
        rst_in = 1'b0;
        #2 chk("g_ptr_reset", {30'h0, bus.req_ready}, 32'h1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
